// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// the flush filler word and a word-alignment helper.
package fetch_unit_pkg;

    // FETCH: no stale responses pending; DRAIN: dropping pre-redirect responses.
    typedef enum logic {
        FETCH_S = 1'b0,
        DRAIN_S = 1'b1
    } state_t;

    // Word presented toward decode whenever the queue head is not valid.
    localparam logic [31:0] INSTR_NOP = 32'h0;

    // Clears the byte offset of an address so fetches are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_instr_fifo.sv
// Synchronous FIFO with flush. The head entry is read straight out of the
// storage registers, so a word pushed at one edge is visible after that edge.
// Used both as the prefetch queue and as the in-flight fetch address tracker.
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~w_full | w_do_pop);
    assign rdata     = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Entry storage; contents are only meaningful under a valid pointer.
    always_ff @(posedge clk) begin
        if (rst && !flush && w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

    // Pushing into a full FIFO without a simultaneous pop would lose a word.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst || flush)
        !(push && w_full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues credit-limited word fetches,
// tags returned words with their fetch address and queues them for decode.
// A redirect flushes the queue and marks every in-flight response as stale.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_pc;
    logic [CW-1:0] r_discard;
    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] w_discard_next;
    logic [CW-1:0] w_out_next;
    logic [CW-1:0] w_q_count;
    logic [CW-1:0] w_outstanding;
    logic [CW:0]   w_credits_used;
    logic          w_fire;
    logic          w_rsp;
    logic          w_q_push;
    logic          w_q_pop;
    logic          w_q_empty;
    logic          w_a_empty;
    logic [31:0]   w_rsp_pc;
    logic [31:0]   w_redirect_target;
    logic [63:0]   w_q_wdata;
    logic [63:0]   w_q_head;

    // Queued words plus fetches still in flight may never exceed the queue size.
    assign w_credits_used    = {1'b0, w_q_count} + {1'b0, w_outstanding};
    assign imem_req          = rst & ~redirect_valid & (w_credits_used < (CW+1)'(DEPTH));
    assign imem_addr         = r_pc;
    assign w_fire            = imem_req & imem_ready;
    assign w_rsp             = imem_rvalid & ~w_a_empty;
    assign w_redirect_target = word_align(redirect_pc);

    // A response is kept only when it is not stale and no redirect is flushing.
    assign w_q_push    = w_rsp & (r_discard == '0) & ~redirect_valid;
    assign w_q_pop     = instr_ready & ~w_q_empty & ~redirect_valid;
    assign w_q_wdata   = {w_rsp_pc, imem_rdata};
    assign instr_valid = ~w_q_empty;
    assign instr       = w_q_empty ? INSTR_NOP : w_q_head[31:0];
    assign instr_pc    = w_q_empty ? 32'h0 : w_q_head[63:32];

    // Prefetch queue of {pc, instr} toward decode.
    instr_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (w_q_push),
        .wdata (w_q_wdata),
        .pop   (w_q_pop),
        .rdata (w_q_head),
        .empty (w_q_empty),
        .count (w_q_count)
    );

    // In-flight addresses: responses return in order, so the head is the
    // address of the next response. Its occupancy is the outstanding count,
    // and stale entries retire alongside their dropped responses.
    instr_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_inflight (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (w_fire),
        .wdata (r_pc),
        .pop   (w_rsp),
        .rdata (w_rsp_pc),
        .empty (w_a_empty),
        .count (w_outstanding)
    );

    // Stale-response bookkeeping: a redirect turns everything still in flight stale.
    always_comb begin
        w_out_next     = w_outstanding + CW'(w_fire) - CW'(w_rsp);
        w_discard_next = r_discard;
        if (redirect_valid) begin
            w_discard_next = w_out_next;
        end else if (w_rsp && (r_discard != '0)) begin
            w_discard_next = r_discard - CW'(1);
        end
    end

    // FSM next state mirrors whether stale responses remain to be dropped.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH_S: if (w_discard_next != '0) w_state_next = DRAIN_S;
            DRAIN_S: if (w_discard_next == '0) w_state_next = FETCH_S;
            default: w_state_next = FETCH_S;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= FETCH_S;
        else      r_state <= w_state_next;
    end

    // PC advance on accept, reload on redirect, and discard counter update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_discard <= '0;
        end else begin
            if (redirect_valid) r_pc <= w_redirect_target;
            else if (w_fire)    r_pc <= r_pc + 32'd4;
            r_discard <= w_discard_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order instruction memory with configurable
// latency, a queue-level reference model of the fetch stage, directed
// scenarios and a randomized run. Inputs change on the falling edge and
// outputs are compared shortly after, once per cycle.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk            = 1'b0;
    logic        rst            = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready     = 1'b0;
    logic        imem_rvalid    = 1'b0;
    logic [31:0] imem_rdata     = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready    = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct { logic [31:0] addr; int due; }          mreq_t;
    typedef struct { logic [31:0] addr; bit stale; }        infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; }  qent_t;

    mreq_t       mq[$];
    infl_t       infl[$];
    qent_t       mdl_q[$];
    logic [31:0] mdl_pc = RESET_PC;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int lat_min  = 1;
    int lat_max  = 1;
    bit chk_en   = 1'b0;

    logic        s_rst = 1'b0, s_ready = 1'b0, s_iready = 1'b0, s_redir = 1'b0;
    logic [31:0] s_rpc = 32'h0;

    logic        smp_req, smp_iv, smp_state;
    logic [31:0] smp_addr, smp_instr, smp_ipc;
    bit          fired, popped;
    logic [31:0] popped_pc;

    logic [31:0] acc[$];
    logic [31:0] pops[$];
    logic [31:0] wrap_exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s at cycle %0d: no event within the cycle budget", name, cyc);
    endtask

    // One clock: drive inputs, compare against the model, advance model and memory.
    task automatic cycle();
        bit          exp_req, exp_iv, exp_state;
        logic [31:0] exp_instr, exp_ipc;
        infl_t       e;
        @(negedge clk);
        rst            = s_rst;
        imem_ready     = s_ready;
        instr_ready    = s_iready;
        redirect_valid = s_redir;
        redirect_pc    = s_rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        exp_req   = s_rst && !s_redir && ((mdl_q.size() + infl.size()) < DEPTH);
        exp_iv    = (mdl_q.size() > 0);
        exp_instr = 32'h0;
        exp_ipc   = 32'h0;
        if (exp_iv) begin
            exp_instr = mdl_q[0].word;
            exp_ipc   = mdl_q[0].pc;
        end
        exp_state = 1'b0;
        foreach (infl[k]) if (infl[k].stale) exp_state = 1'b1;
        smp_req   = imem_req;
        smp_addr  = imem_addr;
        smp_iv    = instr_valid;
        smp_instr = instr;
        smp_ipc   = instr_pc;
        smp_state = dut.r_state;
        if (chk_en) begin
            chk1("imem_req", smp_req, exp_req);
            chk("imem_addr", smp_addr, mdl_pc);
            chk1("instr_valid", smp_iv, exp_iv);
            chk("instr", smp_instr, exp_instr);
            chk("instr_pc", smp_ipc, exp_ipc);
            chk1("fsm_drain", smp_state, exp_state);
        end
        @(posedge clk);
        fired     = exp_req && s_ready;
        popped    = smp_iv && s_iready && !s_redir;
        popped_pc = smp_ipc;
        if (!s_rst) begin
            mq.delete();
            mdl_q.delete();
            infl.delete();
            mdl_pc = RESET_PC;
        end else begin
            if (imem_rvalid) void'(mq.pop_front());
            if (fired) mq.push_back('{addr: mdl_pc, due: cyc + int'($urandom_range(lat_max, lat_min))});
            if (mdl_q.size() > 0 && s_iready && !s_redir) void'(mdl_q.pop_front());
            if (imem_rvalid && infl.size() > 0) begin
                e = infl.pop_front();
                if (!e.stale && !s_redir) mdl_q.push_back('{pc: e.addr, word: imem_rdata});
            end
            if (s_redir) begin
                mdl_q.delete();
                foreach (infl[k]) infl[k].stale = 1'b1;
                mdl_pc = s_rpc & 32'hFFFF_FFFC;
            end else if (fired) begin
                infl.push_back('{addr: mdl_pc, stale: 1'b0});
                mdl_pc = mdl_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        s_rst    = 1'b0;
        s_redir  = 1'b0;
        s_ready  = 1'b0;
        s_iready = 1'b0;
        cycle();
        chk_en = 1'b1;
        cycle();
        cycle();
        s_rst = 1'b1;
    endtask

    task automatic wait_pop(input string name, input logic [31:0] exp_pc, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            if (popped) begin
                got = 1'b1;
                chk(name, popped_pc, exp_pc);
            end
        end
        if (!got) bound_expired(name);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts;
        int npop;
        logic [31:0] exp_next;

        // Reset values.
        do_reset();
        chk1("rst_req", smp_req, 1'b0);
        chk1("rst_instr_valid", smp_iv, 1'b0);
        chk("rst_addr", smp_addr, RESET_PC);
        chk("rst_instr", smp_instr, 32'h0);
        chk("rst_instr_pc", smp_ipc, 32'h0);

        // Sequential fetch, 1-cycle memory, decode always ready.
        lat_min = 1; lat_max = 1; s_ready = 1'b1; s_iready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i == 0) begin
                chk1("t1_first_req", smp_req, 1'b1);
                chk("t1_first_addr", smp_addr, 32'h0);
            end else if (i == 1) begin
                chk1("t1_latency_valid", smp_iv, 1'b0);
            end else begin
                chk1("t1_valid", smp_iv, 1'b1);
                chk("t1_pc", smp_ipc, 32'((i - 2) * 4));
                chk("t1_instr", smp_instr, mem_word(32'((i - 2) * 4)));
            end
        end

        // Decode stalled: credits stop fetch at DEPTH, then resume in order.
        do_reset();
        s_ready = 1'b1; s_iready = 1'b0; accepts = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (smp_req && s_ready) accepts++;
        end
        chk("t2_accepts", 32'(accepts), 32'd4);
        chk1("t2_req_stalled", smp_req, 1'b0);
        chk1("t2_valid_held", smp_iv, 1'b1);
        chk("t2_head_pc", smp_ipc, 32'h0);
        s_iready = 1'b1; exp_next = 32'h0; npop = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (popped) begin
                chk("t2_order", popped_pc, exp_next);
                exp_next = exp_next + 32'd4;
                npop++;
            end
        end
        chk1("t2_resumed", (npop >= 12), 1'b1);

        // Redirect with two responses outstanding on a 3-cycle memory.
        do_reset();
        lat_min = 3; lat_max = 3; s_ready = 1'b1; s_iready = 1'b1;
        cycle();
        cycle();
        s_redir = 1'b1; s_rpc = 32'h0000_0103;
        cycle();
        chk1("t3_req_blocked", smp_req, 1'b0);
        s_redir = 1'b0;
        cycle();
        chk1("t3_drain_1", smp_state, 1'b1);
        chk("t3_new_addr", smp_addr, 32'h0000_0100);
        cycle();
        chk1("t3_drain_2", smp_state, 1'b1);
        cycle();
        chk1("t3_back_to_fetch", smp_state, 1'b0);
        wait_pop("t3_first_after_redirect", 32'h0000_0100, 12);

        // Redirect coinciding with a response and a decode pop.
        do_reset();
        lat_min = 1; lat_max = 1; s_ready = 1'b1; s_iready = 1'b1;
        repeat (3) cycle();
        s_redir = 1'b1; s_rpc = 32'h0000_0200;
        cycle();
        chk1("t4_pre_valid", smp_iv, 1'b1);
        chk("t4_pre_pc", smp_ipc, 32'h4);
        s_redir = 1'b0;
        cycle();
        chk1("t4_flushed", smp_iv, 1'b0);
        chk("t4_target_addr", smp_addr, 32'h0000_0200);
        wait_pop("t4_first_after_redirect", 32'h0000_0200, 10);

        // 32-bit PC wrap.
        do_reset();
        s_ready = 1'b1; s_iready = 1'b1; s_redir = 1'b1; s_rpc = 32'hFFFF_FFF8;
        cycle();
        s_redir = 1'b0;
        acc.delete(); pops.delete();
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (smp_req && s_ready) acc.push_back(smp_addr);
            if (popped) pops.push_back(popped_pc);
        end
        for (int k = 0; k < 3; k++) begin
            chk("t5_accept_addr", (k < acc.size()) ? acc[k] : 32'hDEAD_BEEF, wrap_exp[k]);
            chk("t5_pop_pc", (k < pops.size()) ? pops[k] : 32'hDEAD_BEEF, wrap_exp[k]);
        end

        // Reset asserted while draining stale responses.
        do_reset();
        lat_min = 3; lat_max = 3; s_ready = 1'b1; s_iready = 1'b1;
        cycle();
        cycle();
        s_redir = 1'b1; s_rpc = 32'h0000_0300;
        cycle();
        s_redir = 1'b0; s_rst = 1'b0;
        cycle();
        chk1("t6_in_drain", smp_state, 1'b1);
        cycle();
        chk1("t6_rst_req", smp_req, 1'b0);
        chk("t6_rst_addr", smp_addr, RESET_PC);
        chk1("t6_rst_valid", smp_iv, 1'b0);
        chk("t6_rst_instr", smp_instr, 32'h0);
        chk("t6_rst_pc", smp_ipc, 32'h0);
        chk1("t6_rst_fsm", smp_state, 1'b0);
        s_rst = 1'b1; lat_min = 1; lat_max = 1;
        cycle();
        chk1("t6_refetch_req", smp_req, 1'b1);
        chk("t6_refetch_addr", smp_addr, RESET_PC);
        wait_pop("t6_first_after_reset", RESET_PC, 10);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0) begin
                lat_min = 1;
                lat_max = 1 + int'($urandom_range(3, 0));
            end
            s_rst    = ($urandom_range(299, 0) != 0);
            s_ready  = ($urandom_range(9, 0) < 7);
            s_iready = ($urandom_range(9, 0) < 7);
            s_redir  = ($urandom_range(99, 0) < 6);
            s_rpc    = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
